// File: rtl/encoder_input_conditioner_if.sv
// Pin-side bundle for one quadrature encoder front end.
// master: whoever drives the raw pins and err_clear; slave: the conditioner itself.
interface encoder_input_conditioner_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 A_raw;
    logic                 B_raw;
    logic                 I_raw;
    logic                 err_clear;
    logic                 A;
    logic                 B;
    logic                 I;
    logic                 index_pulse;
    logic                 illegal;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output A_raw, B_raw, I_raw, err_clear,
        input  A, B, I, index_pulse, illegal, err_count
    );

    modport slave (
        input  A_raw, B_raw, I_raw, err_clear,
        output A, B, I, index_pulse, illegal, err_count
    );
endinterface

// File: rtl/encoder_input_conditioner.sv
// Quadrature encoder input conditioner: per-pin synchroniser + stability filter,
// index-edge pulse and illegal A/B transition detection.
// Optional build macro ENC_ERROR_COUNT_EN adds a saturating illegal-event counter;
// without it err_count is tied to 0 and err_clear is ignored.

// One pin: synchroniser chain followed by a stability-window filter.
module enc_chan_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic filt
);
    localparam int                CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    // Shift raw pin through the sync chain; output follows only after FILTER_LEN stable cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt    <= '0;
            filt   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (s == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= s;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module encoder_input_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8,
    parameter int ERR_CNT_W   = 8
) (
    input logic                         clk_12MHz,
    input logic                         reset,
    encoder_input_conditioner_if.slave  bus
);
    localparam int NUM_CH     = 3;                         // bit 0 = A, 1 = B, 2 = I
    localparam int SETTLE_LEN = SYNC_STAGES + FILTER_LEN + 1;
    localparam int SET_W      = $clog2(SETTLE_LEN);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_LEN - 1);

    typedef enum logic {SETTLE, RUN} state_t;

    logic [NUM_CH-1:0] raw_vec;
    logic [NUM_CH-1:0] filt_vec;
    logic [NUM_CH-1:0] filt_d;
    state_t            state;
    logic [SET_W-1:0]  settle_cnt;
    logic              index_pulse_q;
    logic              illegal_q;

    assign raw_vec = {bus.I_raw, bus.B_raw, bus.A_raw};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        enc_chan_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_chan (
            .clk   (clk_12MHz),
            .reset (reset),
            .raw   (raw_vec[ch]),
            .filt  (filt_vec[ch])
        );
    end

    // SETTLE hides the post-reset catch-up of the filters; RUN emits registered edge events.
    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state         <= SETTLE;
            settle_cnt    <= '0;
            filt_d        <= '0;
            index_pulse_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            filt_d        <= filt_vec;
            index_pulse_q <= 1'b0;
            illegal_q     <= 1'b0;
            case (state)
                SETTLE: begin
                    if (settle_cnt == SET_LAST) state <= RUN;
                    else                        settle_cnt <= settle_cnt + 1'b1;
                end
                RUN: begin
                    index_pulse_q <= filt_vec[2] & ~filt_d[2];
                    illegal_q     <= (filt_vec[0] ^ filt_d[0]) & (filt_vec[1] ^ filt_d[1]);
                end
                default: state <= SETTLE;
            endcase
        end
    end

    assign bus.A           = filt_vec[0];
    assign bus.B           = filt_vec[1];
    assign bus.I           = filt_vec[2];
    assign bus.index_pulse = index_pulse_q;
    assign bus.illegal     = illegal_q;

`ifdef ENC_ERROR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Saturating count of illegal pulses; clear takes priority over a coincident pulse.
    always_ff @(posedge clk_12MHz) begin
        if (reset || bus.err_clear)            err_cnt_q <= '0;
        else if (illegal_q && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end

    assign bus.err_count = err_cnt_q;
`else
    assign bus.err_count = '0;
`endif
endmodule
